dec_2_to_4_seq: RTL
===================

Name: dec_2_to_4_seq

Overview:
- Registered 2-to-4 decoder; the receiving end of the 4-to-2 encoder path.
- Accepts the 2-bit code {E1,E0} over a valid/ready handshake and drives the matching one-hot line Y for a programmable hold time.
- An idle-time scan mode walks Y through all four lines, for lamp/digit-select test of the downstream board.
- Sits directly after the encoder output register in the lab datapath.

Parameters:
- HOLD_CYCLES, 4: cycles Y stays asserted per accepted code; must be ≥1.
- SCAN_DIV, 8: cycles each one-hot step lasts in scan mode; must be ≥1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- E0  in  1  code LSB, matching the encoder E0 output.
- E1  in  1  code MSB, matching the encoder E1 output.
- in_valid  in  1  code present on E1/E0.
- in_ready  out  1  block can accept a code this cycle.
- en  in  1  global enable.
- scan_en  in  1  request scan mode.
- Y  out  4  one-hot decoded output; Y[0]=A, Y[1]=B, Y[2]=C, Y[3]=D.
- out_valid  out  1  one-cycle pulse on the first cycle of a decoded Y.
- busy  out  1  high in HOLD or SCAN.

Behaviour:
- Reset (async, rst_n=0): Y=4'b0000, out_valid=0, busy=0, state=IDLE, hold and scan counters=0.
  - in_ready is combinational: 1 only in IDLE with en=1, so it reads 1 while reset is released and en=1.
  - Asserting reset mid-HOLD or mid-SCAN clears all outputs immediately, without waiting for a clock edge.
- Code map (E1E0 → Y): 00→0001, 01→0010, 10→0100, 11→1000. This is the inverse of the encoder.
- State IDLE:
  - in_ready=en; Y=0.
  - Handshake is in_valid & in_ready at edge N. At that edge: register Y=onehot({E1,E0}), out_valid=1, hold_cnt=HOLD_CYCLES-1, go to HOLD.
  - Latency is 1 cycle: Y is visible from edge N.
  - If there is no handshake and scan_en=1 and en=1: go to SCAN with Y=0001 and scan_cnt=SCAN_DIV-1.
  - Handshake has priority over scan_en on the same cycle.
- State HOLD:
  - in_ready=0, busy=1, Y held. out_valid clears after one cycle.
  - Each edge: if hold_cnt==0, Y=0 and go to IDLE; else hold_cnt decrements.
  - Y is therefore nonzero for exactly HOLD_CYCLES cycles.
  - Minimum handshake-to-handshake spacing is HOLD_CYCLES+1 cycles.
  - E1/E0 changing during HOLD has no effect.
- State SCAN:
  - in_ready=0, busy=1, out_valid=0.
  - Each edge: if scan_cnt==0, rotate Y left by one (1000 wraps to 0001) and reload scan_cnt=SCAN_DIV-1; else scan_cnt decrements.
  - scan_en=0 sampled at an edge: Y=0, go to IDLE. A scan_en drop mid-step does not finish the current step.
- en=0:
  - IDLE: in_ready=0; in_valid and scan_en are ignored.
  - HOLD or SCAN: abort at the next edge with Y=0, go to IDLE, no out_valid.
- Invariants: Y is always 0000 or exactly one-hot. out_valid=1 implies Y≠0.
- Counter width: $clog2 of max(HOLD_CYCLES, SCAN_DIV), minimum 1 bit. Counters must never underflow.

Decomposition:
- Package dec_pkg holds:
  - state encoding constants: IDLE=2'd0, HOLD=2'd1, SCAN=2'd2;
  - the code-to-one-hot mapping function;
  - the counter-width helper.
- One sub-module, dec_scan_ticker: a down-counter with load value and enable that emits a one-cycle tick at zero. It is instantiated once and shared for hold and scan timing.

Test Plan:
- Reset with rst_n=0 asserted mid-cycle → Y=0000, out_valid=0, busy=0 immediately. After release with en=1 → in_ready=1.
- Codes 00, 01, 10, 11 each sent with in_valid=1 and HOLD_CYCLES=4 → Y=0001, 0010, 0100, 1000 respectively, each for exactly 4 cycles. out_valid pulses on the first of those cycles; in_ready stays 0 for those 4 cycles and returns to 1 on the 5th.
- Hold in_valid=1 continuously with changing codes → codes accepted only every 5 cycles. Y matches the code sampled at each handshake edge; codes applied during HOLD are ignored.
- scan_en=1 in IDLE with SCAN_DIV=8 → Y sequence 0001, 0010, 0100, 1000, 0001, with 8 cycles per step. Drop scan_en → Y=0000 at the next edge and in_ready=1.
- in_valid=1 and scan_en=1 on the same cycle with code 10 → HOLD entered with Y=0100, no scan. en=0 in the 2nd HOLD cycle → Y=0000 at the next edge; IDLE with in_ready=0 until en returns to 1.
- HOLD_CYCLES=1 and SCAN_DIV=1 build → a single-cycle Y pulse per code. Scan rotates every cycle.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared definitions for the registered 2-to-4 decoder: state encoding,
// code-to-one-hot mapping and the counter width helper.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } dec_state_t;

  // Inverse of the 4-to-2 encoder: E1E0 selects one of the four lines A..D.
  function automatic logic [3:0] code_to_onehot(input logic [1:0] code);
    logic [3:0] onehot;
    case (code)
      2'b00:   onehot = 4'b0001;
      2'b01:   onehot = 4'b0010;
      2'b10:   onehot = 4'b0100;
      2'b11:   onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

  // Width needed to hold a reload value of max(a,b)-1; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int biggest;
    int w;
    biggest = (a > b) ? a : b;
    w = $clog2(biggest);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dec_scan_ticker.sv
// Loadable down-counter with a zero tick. One instance times both the HOLD
// interval and each SCAN step; it stops at zero instead of wrapping.
module dec_scan_ticker #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  output logic         tick
);

  logic [W-1:0] cnt_r;

  // Counter register: clear wins over load, load wins over decrement, hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec_en && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = (cnt_r == '0);

endmodule

// File: rtl/dec_2_to_4_seq.sv
// Registered 2-to-4 decoder with valid/ready intake, programmable output
// hold time and an idle-time scan mode that walks Y across all four lines.
module dec_2_to_4_seq
  import dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int SCAN_DIV    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       E0,
  input  logic       E1,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       en,
  input  logic       scan_en,
  output logic [3:0] Y,
  output logic       out_valid,
  output logic       busy
);

  localparam int CW = cnt_width(HOLD_CYCLES, SCAN_DIV);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SCAN_LOAD = CW'(SCAN_DIV - 1);

  dec_state_t    state_r;
  dec_state_t    state_nxt_s;
  logic [3:0]    y_r;
  logic [3:0]    y_nxt_s;
  logic          out_valid_r;
  logic          out_valid_nxt_s;
  logic          tick_s;
  logic          ld_s;
  logic [CW-1:0] ld_val_s;
  logic          dec_s;
  logic          clr_s;
  logic          accept_s;

  // Handshake can only complete in IDLE while globally enabled.
  assign in_ready = (state_r == IDLE) && en;
  assign accept_s = in_ready && in_valid;

  dec_scan_ticker #(
    .W (CW)
  ) u_ticker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_s),
    .load     (ld_s),
    .load_val (ld_val_s),
    .dec_en   (dec_s),
    .tick     (tick_s)
  );

  // Next-state and next-output logic; every path leaves Y zero or one-hot.
  always_comb begin
    state_nxt_s     = state_r;
    y_nxt_s         = y_r;
    out_valid_nxt_s = 1'b0;
    ld_s            = 1'b0;
    ld_val_s        = HOLD_LOAD;
    dec_s           = 1'b0;
    clr_s           = 1'b0;
    case (state_r)
      IDLE: begin
        y_nxt_s = 4'b0000;
        if (accept_s) begin
          // Handshake beats a simultaneous scan request.
          state_nxt_s     = HOLD;
          y_nxt_s         = code_to_onehot({E1, E0});
          out_valid_nxt_s = 1'b1;
          ld_s            = 1'b1;
          ld_val_s        = HOLD_LOAD;
        end else if (en && scan_en) begin
          state_nxt_s = SCAN;
          y_nxt_s     = 4'b0001;
          ld_s        = 1'b1;
          ld_val_s    = SCAN_LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (!en) begin
          state_nxt_s = IDLE;
          y_nxt_s     = 4'b0000;
          clr_s       = 1'b1;
        end else if (tick_s) begin
          state_nxt_s = IDLE;
          y_nxt_s     = 4'b0000;
        end else begin
          dec_s = 1'b1;
        end
      end
      SCAN: begin
        if (!en || !scan_en) begin
          // Leaving scan drops the current step immediately.
          state_nxt_s = IDLE;
          y_nxt_s     = 4'b0000;
          clr_s       = 1'b1;
        end else if (tick_s) begin
          y_nxt_s  = {y_r[2:0], y_r[3]};
          ld_s     = 1'b1;
          ld_val_s = SCAN_LOAD;
        end else begin
          dec_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        y_nxt_s     = 4'b0000;
        clr_s       = 1'b1;
      end
    endcase
  end

  // State and output registers; reset clears Y and out_valid without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      y_r         <= 4'b0000;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      y_r         <= y_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  assign Y         = y_r;
  assign out_valid = out_valid_r;
  assign busy      = (state_r != IDLE);

endmodule
